// File: rtl/jesd_8b10b_pkg.sv
// Shared 8b/10b constants for the JESD204B transmit path: K-character octets,
// their RD-/RD+ code groups (abcdeifghj, a = bit 9) and the running-disparity encoding.
package jesd_8b10b_pkg;

   typedef enum logic {
      RD_NEG = 1'b0,
      RD_POS = 1'b1
   } rd_t;

   localparam logic [9:0] RESET_CODE_DEF = 10'h274;   // D0.0 RD-

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_1 = 8'h3C;
   localparam logic [7:0] K28_2 = 8'h5C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_6 = 8'hDC;
   localparam logic [7:0] K28_7 = 8'hFC;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;

   localparam logic [9:0] K28_0_RDM = 10'h0F4;
   localparam logic [9:0] K28_0_RDP = 10'h30B;
   localparam logic [9:0] K28_1_RDM = 10'h0F9;
   localparam logic [9:0] K28_1_RDP = 10'h306;
   localparam logic [9:0] K28_2_RDM = 10'h0F5;
   localparam logic [9:0] K28_2_RDP = 10'h30A;
   localparam logic [9:0] K28_3_RDM = 10'h0F3;
   localparam logic [9:0] K28_3_RDP = 10'h30C;
   localparam logic [9:0] K28_4_RDM = 10'h0F2;
   localparam logic [9:0] K28_4_RDP = 10'h30D;
   localparam logic [9:0] K28_5_RDM = 10'h0FA;
   localparam logic [9:0] K28_5_RDP = 10'h305;
   localparam logic [9:0] K28_6_RDM = 10'h0F6;
   localparam logic [9:0] K28_6_RDP = 10'h309;
   localparam logic [9:0] K28_7_RDM = 10'h0F8;
   localparam logic [9:0] K28_7_RDP = 10'h307;
   localparam logic [9:0] K23_7_RDM = 10'h3A8;
   localparam logic [9:0] K23_7_RDP = 10'h057;
   localparam logic [9:0] K27_7_RDM = 10'h368;
   localparam logic [9:0] K27_7_RDP = 10'h097;
   localparam logic [9:0] K29_7_RDM = 10'h2E8;
   localparam logic [9:0] K29_7_RDP = 10'h117;
   localparam logic [9:0] K30_7_RDM = 10'h1E8;
   localparam logic [9:0] K30_7_RDP = 10'h217;

endpackage

// File: rtl/jesd_8b10b_rd_ctrl_popcount10.sv
// Combinational ones counter for a 10-bit code group.
module popcount10 (
   input  logic [9:0] i_bits,
   output logic [3:0] o_ones
);

   always_comb begin
      o_ones = 4'd0;
      for (int i = 0; i < 10; i++) begin
         o_ones = o_ones + {3'd0, i_bits[i]};
      end
   end

endmodule

// File: rtl/jesd_8b10b_rd_ctrl.sv
// Running-disparity controller: picks the RD-/RD+ ROM result by current RD,
// tracks RD from the chosen symbol's ones-count and registers it for the serializer.
module jesd_8b10b_rd_ctrl
   import jesd_8b10b_pkg::*;
#(
   parameter logic [9:0] RESET_CODE = RESET_CODE_DEF,
   parameter int         CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           i_data,
   input  logic                 i_k,
   input  logic                 i_valid,
   input  logic                 i_rd_clr,
   output logic [7:0]           o_rom_addr,
   output logic                 o_rom_rd_en,
   output logic                 o_rom_k,
   input  logic [9:0]           i_rdm_code,
   input  logic                 i_rdm_k_error,
   input  logic [9:0]           i_rdp_code,
   input  logic                 i_rdp_k_error,
   output logic [9:0]           o_code,
   output logic                 o_valid,
   output logic                 o_k_error,
   output logic                 o_disp_error,
   output logic                 o_rd,
   output logic [CNT_WIDTH-1:0] o_disp_err_cnt
);

   logic                 r_valid_d1;
   rd_t                  r_rd;
   logic [9:0]           r_code;
   logic                 r_valid;
   logic                 r_k_error;
   logic                 r_disp_error;
   logic [CNT_WIDTH-1:0] r_cnt;

   logic [9:0] w_sel;
   logic       w_kerr;
   logic [3:0] w_ones;
   logic       w_legal;
   rd_t        w_rd_next;

   assign o_rom_addr  = i_data;
   assign o_rom_rd_en = i_valid;
   assign o_rom_k     = i_k;

   assign w_sel  = (r_rd == RD_POS) ? i_rdp_code    : i_rdm_code;
   assign w_kerr = (r_rd == RD_POS) ? i_rdp_k_error : i_rdm_k_error;

   popcount10 u_popcount (
      .i_bits (w_sel),
      .o_ones (w_ones)
   );

   // A balanced symbol keeps RD; an unbalanced one must push RD toward the other side.
   always_comb begin
      w_legal   = 1'b0;
      w_rd_next = r_rd;
      if (w_ones == 4'd5) begin
         w_legal = 1'b1;
      end else if ((w_ones == 4'd6) && (r_rd == RD_NEG)) begin
         w_legal = 1'b1;
         if (r_valid_d1) w_rd_next = RD_POS;
      end else if ((w_ones == 4'd4) && (r_rd == RD_POS)) begin
         w_legal = 1'b1;
         if (r_valid_d1) w_rd_next = RD_NEG;
      end
      if (i_rd_clr) begin
         w_rd_next = RD_NEG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_d1   <= 1'b0;
         r_rd         <= RD_NEG;
         r_code       <= RESET_CODE;
         r_valid      <= 1'b0;
         r_k_error    <= 1'b0;
         r_disp_error <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_valid_d1   <= i_valid;
         r_rd         <= w_rd_next;
         r_valid      <= r_valid_d1;
         r_k_error    <= r_valid_d1 & w_kerr;
         r_disp_error <= r_valid_d1 & ~w_legal;
         if (r_valid_d1) begin
            r_code <= w_sel;
         end
         if (r_valid_d1 && !w_legal && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_code         = r_code;
   assign o_valid        = r_valid;
   assign o_k_error      = r_k_error;
   assign o_disp_error   = r_disp_error;
   assign o_rd           = r_rd;
   assign o_disp_err_cnt = r_cnt;

endmodule

// File: tb/tb_jesd_8b10b_rd_ctrl.sv
// Bench for jesd_8b10b_rd_ctrl: registered ROM stand-in, disparity-arithmetic
// reference model compared every cycle, plus hand-computed literal checkpoints.
module tb_jesd_8b10b_rd_ctrl;
   import jesd_8b10b_pkg::*;

   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [7:0]    i_data = '0;
   logic          i_k = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_rd_clr = 1'b0;
   logic [7:0]    o_rom_addr;
   logic          o_rom_rd_en;
   logic          o_rom_k;
   logic [9:0]    i_rdm_code = '0;
   logic          i_rdm_k_error = 1'b0;
   logic [9:0]    i_rdp_code = '0;
   logic          i_rdp_k_error = 1'b0;
   logic [9:0]    o_code;
   logic          o_valid;
   logic          o_k_error;
   logic          o_disp_error;
   logic          o_rd;
   logic [CW-1:0] o_disp_err_cnt;

   // ROM contents the bench associates with the current request
   logic [9:0] rom_rdm = 10'h3FF;
   logic [9:0] rom_rdp = 10'h3FF;
   logic       rom_km  = 1'b0;
   logic       rom_kp  = 1'b0;

   int checks = 0;
   int errors = 0;

   jesd_8b10b_rd_ctrl #(
      .RESET_CODE (10'h274),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_data         (i_data),
      .i_k            (i_k),
      .i_valid        (i_valid),
      .i_rd_clr       (i_rd_clr),
      .o_rom_addr     (o_rom_addr),
      .o_rom_rd_en    (o_rom_rd_en),
      .o_rom_k        (o_rom_k),
      .i_rdm_code     (i_rdm_code),
      .i_rdm_k_error  (i_rdm_k_error),
      .i_rdp_code     (i_rdp_code),
      .i_rdp_k_error  (i_rdp_k_error),
      .o_code         (o_code),
      .o_valid        (o_valid),
      .o_k_error      (o_k_error),
      .o_disp_error   (o_disp_error),
      .o_rd           (o_rd),
      .o_disp_err_cnt (o_disp_err_cnt)
   );

   always #5 clk = ~clk;

   // ROM with one cycle of read latency
   always @(posedge clk) begin
      i_rdm_code    <= rom_rdm;
      i_rdp_code    <= rom_rdp;
      i_rdm_k_error <= rom_km;
      i_rdp_k_error <= rom_kp;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each request is resolved one cycle after it is issued,
   // using signed disparity (2*ones - 10) against the running disparity.
   logic       m_s1_v = 1'b0;
   logic [9:0] m_s1_rdm, m_s1_rdp;
   logic       m_s1_km, m_s1_kp;
   logic       m_rd = 1'b0;
   logic [9:0] m_code = 10'h274;
   logic       m_valid = 1'b0, m_kerr = 1'b0, m_derr = 1'b0;
   int         m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1_v  <= 1'b0;
         m_rd    <= 1'b0;
         m_code  <= 10'h274;
         m_valid <= 1'b0;
         m_kerr  <= 1'b0;
         m_derr  <= 1'b0;
         m_cnt   <= 0;
      end else begin : model_step
         logic [9:0] sel;
         int         disp;
         logic       legal;
         logic       nrd;
         nrd = m_rd;
         m_valid <= m_s1_v;
         m_kerr  <= 1'b0;
         m_derr  <= 1'b0;
         if (m_s1_v) begin
            sel   = m_rd ? m_s1_rdp : m_s1_rdm;
            disp  = 2 * $countones(sel) - 10;
            legal = (disp == 0) || (disp == 2 && !m_rd) || (disp == -2 && m_rd);
            if (legal && disp != 0) nrd = !m_rd;
            m_code <= sel;
            m_kerr <= m_rd ? m_s1_kp : m_s1_km;
            m_derr <= !legal;
            if (!legal && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
         end
         if (i_rd_clr) nrd = 1'b0;
         m_rd     <= nrd;
         m_s1_v   <= i_valid;
         m_s1_rdm <= rom_rdm;
         m_s1_rdp <= rom_rdp;
         m_s1_km  <= rom_km;
         m_s1_kp  <= rom_kp;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("rom_addr", 32'(o_rom_addr), 32'(i_data));
         check("rom_rd_en", 32'(o_rom_rd_en), 32'(i_valid));
         check("rom_k", 32'(o_rom_k), 32'(i_k));
         check("valid", 32'(o_valid), 32'(m_valid));
         check("code", 32'(o_code), 32'(m_code));
         check("k_error", 32'(o_k_error), 32'(m_kerr));
         check("disp_error", 32'(o_disp_error), 32'(m_derr));
         check("rd", 32'(o_rd), 32'(m_rd));
         check("err_cnt", 32'(o_disp_err_cnt), 32'(m_cnt));
         if (o_valid)
            $display("sym code=0x%03h kerr=%0b derr=%0b rd=%0b cnt=%0d",
                     o_code, o_k_error, o_disp_error, o_rd, o_disp_err_cnt);
      end
   end

   // Drive one cycle of inputs, then advance to just after the next rising edge.
   task automatic step(input logic v, input logic [7:0] d, input logic k,
                       input logic [9:0] rdm, input logic [9:0] rdp,
                       input logic km, input logic kp, input logic clr);
      i_valid  = v;
      i_data   = d;
      i_k      = k;
      i_rd_clr = clr;
      rom_rdm  = v ? rdm : 10'h3FF;
      rom_rdp  = v ? rdp : 10'h3FF;
      rom_km   = v ? km : 1'b1;
      rom_kp   = v ? kp : 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [9:0] k285_exp [4];
   logic       k285_rd  [4];

   initial begin
      k285_exp = '{10'h0FA, 10'h305, 10'h0FA, 10'h305};
      k285_rd  = '{1'b1, 1'b0, 1'b1, 1'b0};

      #3 rst_n = 1'b0;
      #1;
      check("lit_reset_code", 32'(o_code), 32'h274);
      check("lit_reset_valid", 32'(o_valid), 32'h0);
      check("lit_reset_rd", 32'(o_rd), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // D0.0 request
      step(1'b1, 8'h00, 1'b0, 10'h274, 10'h18B, 1'b0, 1'b0, 1'b0);
      idle();
      check("lit_d00_valid", 32'(o_valid), 32'h1);
      check("lit_d00_code", 32'(o_code), 32'h274);
      check("lit_d00_rd", 32'(o_rd), 32'h0);

      // K28.5 stream: alternating disparity
      for (int i = 0; i < 4; i++) begin
         step(1'b1, K28_5, 1'b1, K28_5_RDM, K28_5_RDP, 1'b0, 1'b0, 1'b0);
         if (i >= 1) begin
            check("lit_k285_code", 32'(o_code), 32'(k285_exp[i-1]));
            check("lit_k285_rd", 32'(o_rd), 32'(k285_rd[i-1]));
         end
      end
      idle();
      check("lit_k285_code", 32'(o_code), 32'(k285_exp[3]));
      check("lit_k285_rd", 32'(o_rd), 32'(k285_rd[3]));

      // invalid K flagged by the ROM
      step(1'b1, 8'h00, 1'b1, K28_0_RDM, K28_0_RDP, 1'b1, 1'b1, 1'b0);
      idle();
      check("lit_kerr_code", 32'(o_code), 32'h0F4);
      check("lit_kerr_flag", 32'(o_k_error), 32'h1);
      check("lit_kerr_rd", 32'(o_rd), 32'h0);

      // 7-ones symbol injected back to back: counter must saturate
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'h55, 1'b0, 10'h3F8, 10'h3F8, 1'b0, 1'b0, 1'b0);
         if (i == 1) begin
            check("lit_derr_flag", 32'(o_disp_error), 32'h1);
            check("lit_derr_cnt1", 32'(o_disp_err_cnt), 32'h1);
         end
      end
      idle();
      idle();
      check("lit_derr_sat", 32'(o_disp_err_cnt), 32'(CNT_MAX));
      check("lit_derr_rd", 32'(o_rd), 32'h0);

      // RD clear while a symbol is in stage 2 with RD positive
      step(1'b1, K28_5, 1'b1, K28_5_RDM, K28_5_RDP, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b0, 10'h274, 10'h18B, 1'b0, 1'b0, 1'b0);
      check("lit_pre_clr_rd", 32'(o_rd), 32'h1);
      step(1'b0, 8'h00, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b1);
      check("lit_clr_code", 32'(o_code), 32'h18B);
      check("lit_clr_rd", 32'(o_rd), 32'h0);
      idle();

      // asynchronous reset with a symbol in flight
      step(1'b1, K28_5, 1'b1, K28_5_RDM, K28_5_RDP, 1'b0, 1'b0, 1'b0);
      step(1'b1, K28_5, 1'b1, K28_5_RDM, K28_5_RDP, 1'b0, 1'b0, 1'b0);
      i_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("lit_arst_valid", 32'(o_valid), 32'h0);
      check("lit_arst_code", 32'(o_code), 32'h274);
      check("lit_arst_rd", 32'(o_rd), 32'h0);
      check("lit_arst_cnt", 32'(o_disp_err_cnt), 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         idle();
         check("lit_post_rst_valid", 32'(o_valid), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
